// File: rtl/attn_score_pingpong_buf_pkg.sv
// Shared hyperparameters for the attention datapath and the score-buffer bank states.
package attn_score_pingpong_buf_pkg;

    localparam int unsigned SYSTOLIC_UNIT_NUM = 8;
    localparam int unsigned TIME_STEPS        = 4;

    typedef enum logic [1:0] {
        BankEmpty   = 2'd0,
        BankFilling = 2'd1,
        BankFull    = 2'd2
    } bankState_t;

endpackage

// File: rtl/attn_score_sdp_ram.sv
// Simple dual-port RAM: one write port, one registered read port; maps onto block RAM.
module attn_score_sdp_ram #(
    parameter int unsigned DW    = 16,
    parameter int unsigned DEPTH = 4096,
    parameter int unsigned AW    = 12
) (
    input  logic          s_clk,
    input  logic          s_rst,
    input  logic          wrEn,
    input  logic [AW-1:0] wrAddr,
    input  logic [DW-1:0] wrData,
    input  logic [AW-1:0] rdAddr,
    output logic [DW-1:0] rdData
);

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge s_clk) begin
        if (wrEn) begin
            mem[wrAddr] <= wrData;
        end
    end

    // Only the output register is reset; the array contents survive reset.
    always_ff @(posedge s_clk or negedge s_rst) begin
        if (!s_rst) begin
            rdData <= '0;
        end else begin
            rdData <= mem[rdAddr];
        end
    end

endmodule

// File: rtl/attn_score_pingpong_buf.sv
// Two-bank ping-pong buffer between the Q*K^T score producer and the Attn@V multiplier.
module attn_score_pingpong_buf #(
    parameter int unsigned SYSTOLIC_UNIT_NUM = attn_score_pingpong_buf_pkg::SYSTOLIC_UNIT_NUM,
    parameter int unsigned TIME_STEPS        = attn_score_pingpong_buf_pkg::TIME_STEPS,
    parameter int unsigned DEPTH             = 4096,
    localparam int unsigned SW               = $clog2(2 * SYSTOLIC_UNIT_NUM),
    localparam int unsigned DW               = SW * TIME_STEPS,
    localparam int unsigned AW               = $clog2(DEPTH)
) (
    input  logic          s_clk,
    input  logic          s_rst,
    input  logic          i_score_valid,
    input  logic [DW-1:0] i_score_data,
    input  logic          i_score_last,
    output logic          o_score_ready,
    input  logic          i_AttnRam_Done,
    input  logic [AW-1:0] i_AttnRam_rd_addr,
    output logic          o_AttnRAM_Empty,
    output logic [DW-1:0] o_AttnRAM_data,
    output logic [AW:0]   o_AttnRam_len
);

    import attn_score_pingpong_buf_pkg::*;

    bankState_t    stateQ [2];
    bankState_t    stateD [2];
    logic [AW:0]   lenQ [2];
    logic [AW:0]   lenD [2];
    logic [AW:0]   wrCntQ, wrCntD;
    logic          wrSelQ, wrSelD;
    logic          rdSelQ, rdSelD;
    logic          rdSelDlyQ;
    logic          accept, complete, doneFire;
    logic [DW-1:0] rdData [2];

    assign o_score_ready   = (stateQ[wrSelQ] != BankFull);
    assign o_AttnRAM_Empty = (stateQ[rdSelQ] != BankFull);
    assign o_AttnRam_len   = o_AttnRAM_Empty ? '0 : lenQ[rdSelQ];
    assign o_AttnRAM_data  = rdData[rdSelDlyQ];

    assign accept   = i_score_valid && o_score_ready;
    // A full bank auto-terminates the tile even without last.
    assign complete = accept && (i_score_last || (wrCntQ == (AW + 1)'(DEPTH - 1)));
    assign doneFire = i_AttnRam_Done && (stateQ[rdSelQ] == BankFull);

    // Write completion and Done always touch different banks, so both may apply at once.
    always_comb begin
        stateD = stateQ;
        lenD   = lenQ;
        wrCntD = wrCntQ;
        wrSelD = wrSelQ;
        rdSelD = rdSelQ;
        if (accept) begin
            if (complete) begin
                stateD[wrSelQ] = BankFull;
                lenD[wrSelQ]   = wrCntQ + (AW + 1)'(1);
                wrCntD         = '0;
                wrSelD         = ~wrSelQ;
            end else begin
                stateD[wrSelQ] = BankFilling;
                wrCntD         = wrCntQ + (AW + 1)'(1);
            end
        end
        if (doneFire) begin
            stateD[rdSelQ] = BankEmpty;
            lenD[rdSelQ]   = '0;
            rdSelD         = ~rdSelQ;
        end
    end

    always_ff @(posedge s_clk or negedge s_rst) begin
        if (!s_rst) begin
            for (int b = 0; b < 2; b++) begin
                stateQ[b] <= BankEmpty;
                lenQ[b]   <= '0;
            end
            wrCntQ    <= '0;
            wrSelQ    <= 1'b0;
            rdSelQ    <= 1'b0;
            rdSelDlyQ <= 1'b0;
        end else begin
            stateQ    <= stateD;
            lenQ      <= lenD;
            wrCntQ    <= wrCntD;
            wrSelQ    <= wrSelD;
            rdSelQ    <= rdSelD;
            rdSelDlyQ <= rdSelQ;
        end
    end

    for (genvar b = 0; b < 2; b++) begin : gBank
        attn_score_sdp_ram #(
            .DW   (DW),
            .DEPTH(DEPTH),
            .AW   (AW)
        ) uRam (
            .s_clk (s_clk),
            .s_rst (s_rst),
            .wrEn  (accept && (wrSelQ == 1'(b))),
            .wrAddr(wrCntQ[AW-1:0]),
            .wrData(i_score_data),
            .rdAddr(i_AttnRam_rd_addr),
            .rdData(rdData[b])
        );
    end

endmodule

// File: tb/tb_attn_score_pingpong_buf.sv
// Scoreboard bench for attn_score_pingpong_buf: written words queue up, tile reads pop them.
module tb_attn_score_pingpong_buf;

    localparam int DW    = 16;
    localparam int AW    = 12;
    localparam int DEPTH = 4096;

    logic          s_clk = 1'b0;
    logic          s_rst = 1'b0;
    logic          i_score_valid = 1'b0;
    logic [DW-1:0] i_score_data = '0;
    logic          i_score_last = 1'b0;
    logic          o_score_ready;
    logic          i_AttnRam_Done = 1'b0;
    logic [AW-1:0] i_AttnRam_rd_addr = '0;
    logic          o_AttnRAM_Empty;
    logic [DW-1:0] o_AttnRAM_data;
    logic [AW:0]   o_AttnRam_len;

    int nChecks = 0;
    int nErrors = 0;
    logic [DW-1:0] expQ [$];

    attn_score_pingpong_buf dut (
        .s_clk            (s_clk),
        .s_rst            (s_rst),
        .i_score_valid    (i_score_valid),
        .i_score_data     (i_score_data),
        .i_score_last     (i_score_last),
        .o_score_ready    (o_score_ready),
        .i_AttnRam_Done   (i_AttnRam_Done),
        .i_AttnRam_rd_addr(i_AttnRam_rd_addr),
        .o_AttnRAM_Empty  (o_AttnRAM_Empty),
        .o_AttnRAM_data   (o_AttnRAM_data),
        .o_AttnRam_len    (o_AttnRam_len)
    );

    always #5 s_clk = ~s_clk;

    task automatic step();
        @(posedge s_clk);
        #1;
    endtask

    task automatic expect_status(input string tag, input logic ready, input logic empty,
                                 input int len);
        nChecks++;
        if (o_score_ready !== ready) begin
            nErrors++;
            $display("FAIL %s ready: got %b want %b", tag, o_score_ready, ready);
        end
        nChecks++;
        if (o_AttnRAM_Empty !== empty) begin
            nErrors++;
            $display("FAIL %s empty: got %b want %b", tag, o_AttnRAM_Empty, empty);
        end
        nChecks++;
        if (o_AttnRam_len !== (AW + 1)'(len)) begin
            nErrors++;
            $display("FAIL %s len: got %0d want %0d", tag, o_AttnRam_len, len);
        end
    endtask

    task automatic write_word(input logic [DW-1:0] d, input logic last);
        nChecks++;
        if (o_score_ready !== 1'b1) begin
            nErrors++;
            $display("FAIL write_ready: got %b want 1", o_score_ready);
        end
        i_score_valid = 1'b1;
        i_score_data  = d;
        i_score_last  = last;
        expQ.push_back(d);
        step();
        i_score_valid = 1'b0;
        i_score_last  = 1'b0;
    endtask

    task automatic read_tile(input string tag, input int n);
        logic [DW-1:0] exp;
        nChecks++;
        if (o_AttnRAM_Empty !== 1'b0 || o_AttnRam_len !== (AW + 1)'(n)) begin
            nErrors++;
            $display("FAIL %s tile: got empty=%b len=%0d want empty=0 len=%0d",
                     tag, o_AttnRAM_Empty, o_AttnRam_len, n);
        end
        for (int k = 0; k < n; k++) begin
            i_AttnRam_rd_addr = AW'(k);
            step();
            nChecks++;
            if (expQ.size() == 0) begin
                nErrors++;
                $display("FAIL %s data[%0d]: got %h want nothing queued", tag, k, o_AttnRAM_data);
            end else begin
                exp = expQ.pop_front();
                if (o_AttnRAM_data !== exp) begin
                    nErrors++;
                    $display("FAIL %s data[%0d]: got %h want %h", tag, k, o_AttnRAM_data, exp);
                end
            end
        end
    endtask

    task automatic pulse_done();
        i_AttnRam_Done = 1'b1;
        step();
        i_AttnRam_Done = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        expect_status("reset_held", 1'b1, 1'b1, 0);
        nChecks++;
        if (o_AttnRAM_data !== '0) begin
            nErrors++;
            $display("FAIL reset_data: got %h want 0", o_AttnRAM_data);
        end
        s_rst = 1'b1;
        step();
        step();
        expect_status("reset_idle", 1'b1, 1'b1, 0);
    endtask

    task automatic test_single_tile();
        for (int k = 0; k < 16; k++) begin
            if (k == 15) expect_status("single_before_last", 1'b1, 1'b1, 0);
            write_word(DW'(k * 3), k == 15);
        end
        expect_status("single_after_last", 1'b1, 1'b0, 16);
        read_tile("single", 16);
        pulse_done();
        expect_status("single_done", 1'b1, 1'b1, 0);
    endtask

    task automatic test_pingpong_full();
        for (int k = 0; k < 8; k++) write_word(DW'(16'h0100 + k), k == 7);
        expect_status("pp_first", 1'b1, 1'b0, 8);
        for (int k = 0; k < 8; k++) write_word(DW'(16'h0200 + k), k == 7);
        expect_status("pp_both_full", 1'b0, 1'b0, 8);
        // Offered word while blocked must be dropped.
        i_score_valid = 1'b1;
        i_score_data  = 16'hdead;
        i_score_last  = 1'b1;
        step();
        i_score_valid = 1'b0;
        i_score_last  = 1'b0;
        expect_status("pp_blocked", 1'b0, 1'b0, 8);
        read_tile("pp_tile_a", 8);
        pulse_done();
        expect_status("pp_after_done", 1'b1, 1'b0, 8);
        read_tile("pp_tile_b", 8);
        pulse_done();
        expect_status("pp_drained", 1'b1, 1'b1, 0);
    endtask

    task automatic test_implicit_last();
        for (int k = 0; k < DEPTH; k++) begin
            if (k == DEPTH - 1) expect_status("impl_before_last", 1'b1, 1'b1, 0);
            write_word(DW'(k * 7 + 1), 1'b0);
        end
        expect_status("impl_complete", 1'b1, 1'b0, DEPTH);
        // These land in the other bank and must not disturb the full tile.
        write_word(16'hbeef, 1'b0);
        write_word(16'hcafe, 1'b1);
        expect_status("impl_other_full", 1'b0, 1'b0, DEPTH);
        read_tile("impl_big", DEPTH);
        pulse_done();
        read_tile("impl_small", 2);
        pulse_done();
        expect_status("impl_drained", 1'b1, 1'b1, 0);
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 3; k++) write_word(DW'(16'h0a00 + k), k == 2);
        write_word(16'h0b00, 1'b0);
        write_word(16'h0b01, 1'b0);
        read_tile("b2b_tile_a", 3);
        // Last word of the write bank and Done of the read bank in the same cycle.
        i_score_valid  = 1'b1;
        i_score_data   = 16'h0b02;
        i_score_last   = 1'b1;
        i_AttnRam_Done = 1'b1;
        expQ.push_back(16'h0b02);
        step();
        i_score_valid  = 1'b0;
        i_score_last   = 1'b0;
        i_AttnRam_Done = 1'b0;
        expect_status("b2b_same_cycle", 1'b1, 1'b0, 3);
        read_tile("b2b_tile_b", 3);
        pulse_done();
        expect_status("b2b_drained", 1'b1, 1'b1, 0);
    endtask

    task automatic test_done_empty();
        pulse_done();
        expect_status("done_empty", 1'b1, 1'b1, 0);
        write_word(16'h7777, 1'b1);
        expect_status("single_word", 1'b1, 1'b0, 1);
        read_tile("single_word", 1);
        pulse_done();
        expect_status("single_word_done", 1'b1, 1'b1, 0);
    endtask

    task automatic test_reset_mid_tile();
        for (int k = 0; k < 5; k++) write_word(DW'(16'h0c00 + k), 1'b0);
        s_rst = 1'b0;
        expQ.delete();
        step();
        expect_status("midrst_held", 1'b1, 1'b1, 0);
        nChecks++;
        if (o_AttnRAM_data !== '0) begin
            nErrors++;
            $display("FAIL midrst_data: got %h want 0", o_AttnRAM_data);
        end
        s_rst = 1'b1;
        step();
        expect_status("midrst_idle", 1'b1, 1'b1, 0);
        for (int k = 0; k < 3; k++) write_word(DW'(16'h0d00 + k), k == 2);
        expect_status("midrst_tile", 1'b1, 1'b0, 3);
        read_tile("midrst_tile", 3);
        pulse_done();
        expect_status("midrst_done", 1'b1, 1'b1, 0);
    endtask

    initial begin
        test_reset();
        test_single_tile();
        test_pingpong_full();
        test_implicit_last();
        test_back_to_back();
        test_done_empty();
        test_reset_mid_tile();
        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end

endmodule

// File: doc/attn_score_pingpong_buf.md
# attn_score_pingpong_buf

Two-bank ping-pong buffer for attention-score tiles, between the Q·Kᵀ score producer and the Attn @ V multiply stage (`MM_Calculator`). The producer streams quantized per-timestep spike-count scores in with a valid/ready handshake. The consumer reads a complete tile by address with 1-cycle latency, and releases the tile with a done pulse. While one bank is being read, the other bank fills.

## Interface
- `SYSTOLIC_UNIT_NUM`, default 8: systolic columns; one score field is `SW = $clog2(2*SYSTOLIC_UNIT_NUM)` bits.
- `TIME_STEPS`, default 4: timesteps packed per word; word width `DW = SW*TIME_STEPS`.
- `DEPTH`, default 4096: words per bank; `AW = 12`.

Ports (name, direction, width, meaning):
- `s_clk`  in  1  single clock; all logic on the rising edge.
- `s_rst`  in  1  asynchronous, active-low reset.
- `i_score_valid`  in  1  producer word valid.
- `i_score_data`  in  DW  score word, timestep 0 in LSBs.
- `i_score_last`  in  1  last word of the current tile.
- `o_score_ready`  out  1  write bank accepts a word this cycle.
- `i_AttnRam_Done`  in  1  single-cycle pulse: consumer finished the current read bank.
- `i_AttnRam_rd_addr`  in  AW  read address within the read bank.
- `o_AttnRAM_Empty`  out  1  1 = no complete tile available to read.
- `o_AttnRAM_data`  out  DW  read data, valid 1 cycle after the address.
- `o_AttnRam_len`  out  AW+1  number of words in the read bank; 0 when empty.

## Operation
- Each bank has a 2-bit state: `EMPTY`, `FILLING`, `FULL`. Pointers: `wr_sel` and `rd_sel`, each 1 bit. Write address counter: `wr_cnt`, AW+1 bits. Per-bank length register: `len[b]`.
- A word is accepted only on `i_score_valid && o_score_ready`.
- `o_score_ready = (state[wr_sel] != FULL)`.
- First accepted word moves the write bank EMPTY→FILLING.
- Every accepted word is written at `wr_cnt`, then `wr_cnt` increments.
- Tile completes on an accepted word with `i_score_last=1`, or on an accepted word at `wr_cnt == DEPTH-1` (implicit last). On completion:
  - `state[wr_sel]` becomes FULL.
  - `len[wr_sel]` is set to the word count.
  - `wr_cnt` is set to 0.
  - `wr_sel` toggles.
- A single-word tile (first word carries last) goes EMPTY→FULL directly, with `len` = 1.
- `o_AttnRAM_Empty = (state[rd_sel] != FULL)`.
- `o_AttnRam_len = len[rd_sel]` when the read bank is FULL, otherwise 0.
- `i_AttnRam_Done` while `state[rd_sel] == FULL`: that bank becomes EMPTY, its `len` is cleared, and `rd_sel` toggles.
- `i_AttnRam_Done` while the read bank is not FULL is ignored.
- Simultaneous completion on `wr_sel` and Done on `rd_sel` (different banks): both updates take effect in the same cycle.
- Same-bank conflict is structurally impossible: the write bank is never FULL while accepting, and Done acts only on a FULL bank.
- Reads ignore bank state. Reading while Empty returns whatever the RAM holds; the consumer must not depend on it.

## Timing
- Reset values:
  - `o_score_ready = 1`
  - `o_AttnRAM_Empty = 1`
  - `o_AttnRAM_data = 0`
  - `o_AttnRam_len = 0`
  - both banks EMPTY, both pointers 0, `wr_cnt = 0`
- Reset asserted mid-tile discards all contents and state. RAM arrays are not cleared; only the state registers are reset.
- Read latency: address at cycle t, data registered and valid at t+1.
- Write of the last word at cycle t:
  - Bank is FULL at t+1.
  - If it is the read bank, Empty falls at t+1.
  - If the other bank is FULL, `o_score_ready` falls at t+1.
- Done at cycle t:
  - Released bank is EMPTY at t+1.
  - `o_score_ready` rises at t+1 if the writer was blocked on that bank.
  - At t+1, Empty reflects the newly selected read bank; if that bank is already FULL, Empty stays 0.
- Throughput: one write per cycle and one read per cycle, sustained.
- Outputs are decoded from registers only; no combinational input→output path exists except through the RAM read register.

## Structure
- `SYSTOLIC_UNIT_NUM` and `TIME_STEPS` come from the shared hyperparameter header. Bank state encodings go in the same header as localparams.
- Sub-module `attn_score_sdp_ram`: simple dual-port RAM, DW×DEPTH, one write port and one registered read port, inferable as BRAM. Instantiated twice.
- Read-data mux selects on a 1-cycle-delayed copy of `rd_sel`.

## Test plan
- Reset, then idle: ready=1, Empty=1, len=0, data=0.
- Write 16 words `k*3` with last on word 15, then read addr 0..15: Empty falls the cycle after last, len=16, data[k]=`k*3` at 1-cycle latency. Done → Empty=1, len=0.
- Fill bank 0 (8 words), then bank 1 (8 words) with no Done: ready=0 after the second last. Assert Done: ready=1 next cycle, Empty stays 0, reads return bank-1 data.
- Stream 4096 words with no last: implicit completion, len=4096, `wr_sel` toggles.
- Same-cycle last on bank 1 and Done on bank 0: next cycle both banks are in the correct state and Empty=0 for bank 1.
- Done while Empty: no state change. Reset mid-tile after 5 words: Empty=1, and a new 3-word tile reads back len=3.
